// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose:
//   Game-flow controller. It owns the stage index that drives the platform bar
//   table and decides when the table geometry may change. The flow is
//   title (IDLE) -> transition (TRANS) -> PLAY -> TRANS -> PLAY ... -> WIN or
//   game-over (OVER). The screen is blanked during TRANS, and the stage index
//   only changes on a frame_tick inside TRANS. This means bar geometry only
//   switches while the display is black and on a frame boundary.
//
// Ports:
//   clk           in   1  system clock
//   reset_n       in   1  asynchronous active-low reset
//   frame_tick    in   1  one-cycle pulse at the start of vertical blank
//   start_btn     in   1  debounced one-cycle start pulse
//   stage_clear   in   1  one-cycle pulse: current stage completed
//   player_dead   in   1  one-cycle pulse: player killed
//   stage_number  out  2  stage index driven to the bar table
//   lives         out  2  remaining lives
//   state_code    out  3  0=IDLE 1=PLAY 2=TRANS 3=WIN 4=OVER (state register)
//   blank         out  1  renderer forces a black screen (TRANS only)
//   freeze        out  1  player/enemy motion halted (all states but PLAY)
//   respawn       out  1  one-cycle pulse on the first PLAY cycle after TRANS
//
// Event interface:
//   All inputs are fire-and-forget single-cycle pulses. There is no ready or
//   acknowledge path. A pulse is sampled on exactly one rising clk edge and is
//   judged against the state held before that edge. A pulse that the current
//   state does not react to is dropped and never queued.
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int NUM_STAGES   = 3,   // playable stages, 1..4
  parameter int LIVES        = 3,   // lives loaded at game start, 1..3
  parameter int TRANS_FRAMES = 60   // frame_ticks per transition, >= 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       stage_clear,
  input  logic       player_dead,
  output logic [1:0] stage_number,
  output logic [1:0] lives,
  output logic [2:0] state_code,
  output logic       blank,
  output logic       freeze,
  output logic       respawn
);

  // Transition counter only needs to reach TRANS_FRAMES-1. The width is kept
  // at least 1 bit so that TRANS_FRAMES = 1 still elaborates.
  localparam int CNT_W = (TRANS_FRAMES > 1) ? $clog2(TRANS_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TRANS_FRAMES - 1);
  localparam logic [1:0]       STAGE_LAST = 2'(NUM_STAGES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_TRANS = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [1:0]       stage_q,   stage_d;
  logic [1:0]       lives_q,   lives_d;
  logic [1:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             blank_q,   blank_d;
  logic             freeze_q,  freeze_d;
  logic             respawn_q, respawn_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      stage_q   <= 2'd0;
      lives_q   <= LIVES_INIT;
      pending_q <= 2'd0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      lives_q   <= lives_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    lives_d   = lives_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;

    unique case (state_q)
      // IDLE, WIN and OVER share the same restart behaviour. WIN and OVER
      // keep stage and lives on display until a new game starts.
      S_IDLE, S_WIN, S_OVER: begin
        if (start_btn) begin
          lives_d   = LIVES_INIT;
          pending_d = 2'd0;
          cnt_d     = '0;
          state_d   = S_TRANS;
        end
      end

      S_PLAY: begin
        // A stage clear wins over a death in the same cycle. The player
        // finished the stage, so no life is lost.
        if (stage_clear) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_WIN;
          end else begin
            pending_d = stage_q + 2'd1;
            cnt_d     = '0;
            state_d   = S_TRANS;
          end
        end else if (player_dead) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d   = lives_q - 2'd1;
            pending_d = stage_q;
            cnt_d     = '0;
            state_d   = S_TRANS;
          end
        end
      end

      S_TRANS: begin
        // Game events and start_btn are ignored here. Only the frame clock
        // advances the transition.
        if (frame_tick) begin
          // The count is 0 only on the first tick of a transition. That is
          // where the bar table switches, while the screen is already black.
          if (cnt_q == '0) begin
            stage_d = pending_q;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // These flags are computed from the next state so the registered outputs
    // line up with state_q and add no cycle of lag.
    blank_d  = (state_d == S_TRANS);
    freeze_d = (state_d != S_PLAY);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stage_number = stage_q;
  assign lives        = lives_q;
  assign state_code   = state_q;
  assign blank        = blank_q;
  assign freeze       = freeze_q;
  assign respawn      = respawn_q;

  // ---------------------------------------------------------------------------
  // Invariants: flags consistent with state, counters in range
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_blank_only_trans : assert property (@(posedge clk) disable iff (!reset_n)
    blank_q == (state_q == S_TRANS));
  a_freeze_not_play : assert property (@(posedge clk) disable iff (!reset_n)
    freeze_q == (state_q != S_PLAY));
  a_respawn_in_play : assert property (@(posedge clk) disable iff (!reset_n)
    respawn_q |-> (state_q == S_PLAY));
  a_stage_range : assert property (@(posedge clk) disable iff (!reset_n)
    (stage_q <= STAGE_LAST) && (pending_q <= STAGE_LAST));
  a_cnt_range : assert property (@(posedge clk) disable iff (!reset_n)
    cnt_q <= CNT_LAST);
`endif

endmodule
